ptngen_multi: RTL

PTNGEN_MULTI -- requirements
Module: ptngen_multi

---
 rtl/ptngen_multi.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ptngen_multi.sv
// ptngen_multi: video test-pattern generator driven by external HCNT/VCNT.
// Patterns: solid colour, colour bars, ramp-shaded bars and a checkerboard,
// with horizontal banding that inverts bar colours on even bands.
// The selected pattern is latched once per frame so a frame never tears.
// Optional horizontal scrolling is compiled in with macro PTNGEN_SCROLL_EN;
// without it the scroll offset is a constant zero and no register exists.
module ptngen_multi #(
    parameter int CNT_W       = 10,
    parameter int COLOR_W     = 8,
    parameter int H_BLANK     = 160,
    parameter int H_TOTAL     = 800,
    parameter int V_BLANK     = 45,
    parameter int V_TOTAL     = 525,
    parameter int V_BANDS     = 4,
    parameter int CHECK_LOG2  = 5,
    parameter int GRAD_LSB    = 2,
    parameter int SCROLL_STEP = 4
) (
    input  logic               PCK,
    input  logic               RST,
    input  logic [CNT_W-1:0]   VCNT,
    input  logic [CNT_W-1:0]   HCNT,
    input  logic [1:0]         MODE,
    input  logic [2:0]         SOLID_RGB,
    output logic [COLOR_W-1:0] VGA_R,
    output logic [COLOR_W-1:0] VGA_G,
    output logic [COLOR_W-1:0] VGA_B,
    output logic               VGA_DE,
    output logic [7:0]         FRAME_CNT
);

    localparam int XW     = CNT_W + 1;
    localparam int H_ACT  = H_TOTAL - H_BLANK;
    localparam int BAR_W  = H_ACT / 8;
    localparam int BAND_H = (V_TOTAL - V_BLANK) / V_BANDS;

    typedef enum logic [1:0] {
        PAT_SOLID = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_RAMP  = 2'd2,
        PAT_CHECK = 2'd3
    } pat_e;

    pat_e               mode_q;
    logic [7:0]         frame_q;
    logic [COLOR_W-1:0] r_q, g_q, b_q, r_d, g_d, b_d;
    logic               de_q, de_d;

    logic               active_w, frame_start_w;
    logic [XW-1:0]      x_w, y_w, x_sum_w, x_eff_w, bar_full_w, band_full_w, scroll_w;
    logic [2:0]         bar_w, c3_w;
    logic               band_even_w, chk_w;
    logic [3:0]         g4_w;
    logic [COLOR_W-1:0] ramp_w;

`ifdef PTNGEN_SCROLL_EN
    logic [XW-1:0] scroll_q, scroll_d, scroll_sum_w;

    // Advance the scroll offset by one step per frame, wrapping at the active width.
    always_comb begin
        scroll_sum_w = scroll_q + XW'(SCROLL_STEP);
        scroll_d     = (scroll_sum_w >= XW'(H_ACT)) ? scroll_sum_w - XW'(H_ACT) : scroll_sum_w;
    end

    // Scroll register: cleared by reset, updated only at frame start.
    always_ff @(posedge PCK) begin
        if (RST) begin
            scroll_q <= '0;
        end else if (frame_start_w) begin
            scroll_q <= scroll_d;
        end
    end

    assign scroll_w = scroll_q;
`else
    assign scroll_w = '0;
`endif

    // Pixel coordinates, bar/band indices and per-pattern building blocks.
    always_comb begin
        active_w      = (HCNT >= CNT_W'(H_BLANK - 1)) && (HCNT < CNT_W'(H_TOTAL - 1))
                        && (VCNT >= CNT_W'(V_BLANK));
        frame_start_w = (HCNT == '0) && (VCNT == '0);
        x_w           = {1'b0, HCNT} - XW'(H_BLANK - 1);
        y_w           = {1'b0, VCNT} - XW'(V_BLANK);
        x_sum_w       = x_w + scroll_w;
        x_eff_w       = (x_sum_w >= XW'(H_ACT)) ? x_sum_w - XW'(H_ACT) : x_sum_w;
        bar_full_w    = x_eff_w / XW'(BAR_W);
        // A leftover partial bar at the right edge stays in bar 7 rather than wrapping.
        bar_w         = (bar_full_w > XW'(7)) ? 3'd7 : bar_full_w[2:0];
        band_full_w   = y_w / XW'(BAND_H);
        band_even_w   = ((band_full_w % XW'(2)) == '0);
        c3_w          = band_even_w ? ~bar_w : bar_w;
        g4_w          = x_eff_w[GRAD_LSB+3:GRAD_LSB];
        ramp_w        = {(COLOR_W/4){g4_w}};
        chk_w         = x_eff_w[CHECK_LOG2] ^ y_w[CHECK_LOG2];
    end

    // Select the colour for the current pixel; blanking forces black and DE low.
    always_comb begin
        r_d  = '0;
        g_d  = '0;
        b_d  = '0;
        de_d = 1'b0;
        if (active_w) begin
            de_d = 1'b1;
            unique case (mode_q)
                PAT_SOLID: begin
                    r_d = {COLOR_W{SOLID_RGB[2]}};
                    g_d = {COLOR_W{SOLID_RGB[1]}};
                    b_d = {COLOR_W{SOLID_RGB[0]}};
                end
                PAT_BARS: begin
                    r_d = {COLOR_W{c3_w[2]}};
                    g_d = {COLOR_W{c3_w[1]}};
                    b_d = {COLOR_W{c3_w[0]}};
                end
                PAT_RAMP: begin
                    r_d = c3_w[2] ? ramp_w : '0;
                    g_d = c3_w[1] ? ramp_w : '0;
                    b_d = c3_w[0] ? ramp_w : '0;
                end
                PAT_CHECK: begin
                    r_d = {COLOR_W{chk_w}};
                    g_d = {COLOR_W{chk_w}};
                    b_d = {COLOR_W{chk_w}};
                end
            endcase
        end
    end

    // Registered outputs plus per-frame mode latch and frame counter; reset wins.
    always_ff @(posedge PCK) begin
        if (RST) begin
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            de_q    <= 1'b0;
            mode_q  <= PAT_BARS;
            frame_q <= '0;
        end else begin
            r_q  <= r_d;
            g_q  <= g_d;
            b_q  <= b_d;
            de_q <= de_d;
            if (frame_start_w) begin
                mode_q  <= pat_e'(MODE);
                frame_q <= frame_q + 8'd1;
            end
        end
    end

    assign VGA_R     = r_q;
    assign VGA_G     = g_q;
    assign VGA_B     = b_q;
    assign VGA_DE    = de_q;
    assign FRAME_CNT = frame_q;

endmodule
